uart_echo_responder: RTL

- Responder end of the UART echo link: takes completed bytes from the existing receiver (rx_done/rx_data) and queues them in a small synchronous FIFO.
- Drives the existing transmitter (tx_start/tx_data, tx_done) to send each byte back in order.
- Replaces the ad-hoc single-register echo glue around uart_top.
- Absorbs back-to-back received bytes while the transmitter is busy, and reports overflow and echo statistics.

---
 rtl/uart_echo_pkg.sv | 24 ++
 rtl/uart_echo_fifo.sv | 56 +++++
 rtl/uart_echo_responder.sv | 118 +++++++++++
 3 files changed

// File: rtl/uart_echo_pkg.sv
// Shared types and constants for the UART echo responder: FSM encoding,
// FIFO sizing defaults and the ASCII case-conversion helper.
package uart_echo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } echo_state_t;

    localparam int DEFAULT_DEPTH  = 16;
    localparam int DEFAULT_ADDR_W = 4;

    localparam logic [7:0] ASCII_LOWER_A = 8'h61;
    localparam logic [7:0] ASCII_LOWER_Z = 8'h7A;
    localparam logic [7:0] CASE_DELTA    = 8'h20;

    function automatic logic [7:0] to_upper(input logic [7:0] b);
        if (b >= ASCII_LOWER_A && b <= ASCII_LOWER_Z)
            return b - CASE_DELTA;
        return b;
    endfunction

endpackage

// File: rtl/uart_echo_fifo.sv
// Single-clock byte FIFO; dout always shows the head entry, so a pop and
// its data capture happen on the same edge.
module uart_echo_fifo
    import uart_echo_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [7:0]        din,
    input  logic              pop,
    output logic [7:0]        dout,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_echo_responder.sv
// Queues received bytes and echoes them through the transmitter in order.
// Optional build macro UART_ECHO_UPCASE_EN uppercases ASCII a..z on echo.
module uart_echo_responder
    import uart_echo_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              rx_done,
    input  logic [7:0]        rx_data,
    input  logic              tx_done,
    input  logic              clr_overflow,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              overflow,
    output logic [15:0]       echo_count
);

    localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;

    // Transmitter handshake: tx_start is a one-cycle request with tx_data held
    // until the matching tx_done; a tx_done seen with tx_start still high is
    // not that byte's completion and is ignored, as is any tx_done outside WAIT.
    echo_state_t       state;
    logic [GAP_W-1:0]  gap_cnt;
    logic [7:0]        head;
    logic [7:0]        head_out;
    logic              fifo_push;
    logic              fifo_pop;
    logic              done_ok;
    logic              can_release;

    uart_echo_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (rx_data),
        .pop   (fifo_pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

`ifdef UART_ECHO_UPCASE_EN
    assign head_out = to_upper(head);
`else
    assign head_out = head;
`endif

    assign fifo_push = rx_done && !fifo_full;
    assign done_ok   = tx_done && !tx_start;
    assign busy      = (state != ST_IDLE);

    // Leaving WAIT (no gap) or GAP passes through IDLE in the same edge, so
    // the next pop can fire there and back-to-back echoes lose no cycle.
    assign can_release = (state == ST_IDLE)
                      || (state == ST_WAIT && done_ok && GAP_CYCLES == 0)
                      || (state == ST_GAP  && gap_cnt == '0);
    assign fifo_pop    = can_release && enable && !fifo_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            gap_cnt    <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            overflow   <= 1'b0;
            echo_count <= 16'h0000;
        end else begin
            tx_start <= 1'b0;

            if (rx_done && fifo_full)
                overflow <= 1'b1;
            else if (clr_overflow)
                overflow <= 1'b0;

            if (state == ST_WAIT && done_ok)
                echo_count <= echo_count + 16'd1;

            if (fifo_pop) begin
                tx_data  <= head_out;
                tx_start <= 1'b1;
                state    <= ST_WAIT;
            end else begin
                case (state)
                    ST_IDLE: state <= ST_IDLE;
                    ST_WAIT: begin
                        if (done_ok) begin
                            if (GAP_CYCLES == 0) begin
                                state <= ST_IDLE;
                            end else begin
                                gap_cnt <= GAP_W'(GAP_CYCLES - 1);
                                state   <= ST_GAP;
                            end
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt == '0)
                            state <= ST_IDLE;
                        else
                            gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
